// File: rtl/jt49_exp_pkg.sv
// rtl/jt49_exp_pkg.sv - shared level table, widening helper and FSM state type for jt49_exp_mux
package jt49_exp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] EXP_TBL [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd9,   8'd11,  8'd13,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd107, 8'd128, 8'd152, 8'd180, 8'd214, 8'd255
  };

  function automatic logic [7:0] exp_table(input logic [4:0] lvl);
    return EXP_TBL[lvl];
  endfunction

  // Replicating the top bits into the new LSBs makes T=255 map to all ones at any width.
  function automatic logic [15:0] exp_widen(input logic [7:0] t, input int dw);
    logic [15:0] w;
    w = {8'h00, t};
    return (w << (dw - 8)) | (w >> (16 - dw));
  endfunction

endpackage

// File: rtl/jt49_exp_mux_if.sv
// rtl/jt49_exp_mux_if.sv - frame request and sum result bundle for jt49_exp_mux
interface jt49_exp_mux_if #(
  parameter int CH = 3,
  parameter int DW = 10,
  parameter int SW = DW + $clog2(CH + 1)
);
  logic            start;
  logic [CH*5-1:0] din;
  logic [CH-1:0]   mute;
  logic            busy;
  logic [SW-1:0]   dout;
  logic            dout_valid;

  modport master (output start, din, mute, input busy, dout, dout_valid);
  modport slave  (input start, din, mute, output busy, dout, dout_valid);
endinterface

// File: rtl/jt49_exp_lin.sv
// rtl/jt49_exp_lin.sv - combinational 5-bit log level to DW-bit linear value
module jt49_exp_lin
  import jt49_exp_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic [4:0]    lvl,
  output logic [DW-1:0] lin
);

  assign lin = DW'(exp_widen(exp_table(lvl), DW));

endmodule

// File: rtl/jt49_exp_mux.sv
// rtl/jt49_exp_mux.sv - time-multiplexed log-to-linear channel summer; JT49_EXP_RAMP_EN adds level ramping
module jt49_exp_mux
  import jt49_exp_pkg::*;
#(
  parameter int CH = 3,
  parameter int DW = 10,
  parameter int SW = DW + $clog2(CH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  jt49_exp_mux_if.slave  bus
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   acc;
  logic [4:0]      din_q [CH];
  logic [CH-1:0]   mute_q;
  logic [SW-1:0]   dout_q;
  logic            valid_q;
  logic            last;
  logic [4:0]      lvl;
  logic [DW-1:0]   lin;
  logic [SW-1:0]   addend;

  assign last = (idx == IW'(CH - 1));

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cen && bus.start) state_nx = ST_CONV;
      ST_CONV: if (cen && last)      state_nx = ST_DONE;
      ST_DONE: if (cen)              state_nx = ST_IDLE;
      default:                       state_nx = ST_IDLE;
    endcase
  end

`ifdef JT49_EXP_RAMP_EN
  logic [4:0] ramp_q [CH];
  logic [4:0] tgt;
  logic [4:0] cur;

  // Mute only retargets toward zero so the channel fades instead of clicking off.
  always_comb begin
    cur = ramp_q[idx];
    tgt = mute_q[idx] ? 5'd0 : din_q[idx];
    lvl = cur;
    if (cur < tgt)
      lvl = cur + 5'd1;
    else if (cur > tgt)
      lvl = cur - 5'd1;
    addend = SW'(lin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) ramp_q[k] <= 5'd0;
    end else if (cen && state == ST_CONV) begin
      ramp_q[idx] <= lvl;
    end
  end
`else
  always_comb begin
    lvl    = din_q[idx];
    addend = mute_q[idx] ? '0 : SW'(lin);
  end
`endif

  jt49_exp_lin #(.DW(DW)) u_lin (
    .lvl (lvl),
    .lin (lin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      acc     <= '0;
      mute_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < CH; k++) din_q[k] <= 5'd0;
    end else begin
      valid_q <= 1'b0;
      if (cen) begin
        state <= state_nx;
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              for (int k = 0; k < CH; k++) din_q[k] <= bus.din[5*k +: 5];
              mute_q <= bus.mute;
              acc    <= '0;
              idx    <= '0;
            end
          end
          ST_CONV: begin
            acc <= acc + addend;
            idx <= last ? '0 : idx + IW'(1);
          end
          ST_DONE: begin
            dout_q  <= acc;
            valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy       = (state != ST_IDLE);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;

endmodule

// File: tb/tb_jt49_exp_mux.sv
// tb/tb_jt49_exp_mux.sv - self-checking bench for jt49_exp_mux against a frame-level reference
module tb_jt49_exp_mux;

  localparam int CH  = 3;
  localparam int DW  = 10;
  localparam int SW  = DW + $clog2(CH + 1);
  localparam int SW2 = 8 + $clog2(2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cen   = 1'b0;

  jt49_exp_mux_if #(.CH(CH), .DW(DW), .SW(SW)) bus ();
  jt49_exp_mux_if #(.CH(1),  .DW(8),  .SW(SW2)) bus2 ();

  jt49_exp_mux #(.CH(CH), .DW(DW), .SW(SW)) dut (
    .clk (clk), .rst_n (rst_n), .cen (cen), .bus (bus)
  );

  jt49_exp_mux #(.CH(1), .DW(8), .SW(SW2)) dut2 (
    .clk (clk), .rst_n (rst_n), .cen (cen), .bus (bus2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  int tbl [32] = '{0, 1, 2, 2, 2, 3, 3, 4, 5, 6, 7, 8, 9, 11, 13, 16,
                   19, 23, 27, 32, 38, 45, 54, 64, 76, 90, 107, 128, 152, 180, 214, 255};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lin_of(input int l, input int dw);
    int t;
    t = tbl[l];
    return t * (1 << (dw - 8)) + (t >> (16 - dw));
  endfunction

  // Reference: frame result is computed whole at acceptance, then released CH+1 cen cycles later.
  int cnt;
  int pend;
  int e_dout;
  bit e_valid;
  int app [CH];

  function automatic int frame_sum();
    int s;
    int tgt;
    s = 0;
    for (int k = 0; k < CH; k++) begin
      tgt = bus.mute[k] ? 0 : int'(bus.din[5*k +: 5]);
`ifdef JT49_EXP_RAMP_EN
      if (app[k] < tgt) app[k] = app[k] + 1;
      else if (app[k] > tgt) app[k] = app[k] - 1;
      s += lin_of(app[k], DW);
`else
      s += bus.mute[k] ? 0 : lin_of(tgt, DW);
`endif
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     = 0;
      e_dout  = 0;
      e_valid = 1'b0;
      for (int k = 0; k < CH; k++) app[k] = 0;
    end else begin
      e_valid = 1'b0;
      if (cen) begin
        if (cnt == 0) begin
          if (bus.start) begin
            pend = frame_sum();
            cnt  = CH + 1;
          end
        end else begin
          cnt--;
          if (cnt == 0) begin
            e_valid = 1'b1;
            e_dout  = pend;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy",  int'(bus.busy),       int'(cnt != 0));
      check("dout",  int'(bus.dout),       e_dout);
      check("valid", int'(bus.dout_valid), int'(e_valid));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issues one start and reports the cycles from the accepting edge to dout_valid (-1 on timeout).
  task automatic run_frame(input logic [CH*5-1:0] d, input logic [CH-1:0] m,
                           output int lat, output int val);
    bus.din   = d;
    bus.mute  = m;
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    lat = -1;
    val = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.dout_valid) begin
        lat = i;
        val = int'(bus.dout);
        break;
      end
    end
    if (lat < 0) check("frame_timeout", 0, 1);
    #1;
  endtask

  int lat;
  int val;
  int pulses;
  int first;

  initial begin
    bus.start  = 1'b0;
    bus.din    = '0;
    bus.mute   = '0;
    bus2.start = 1'b0;
    bus2.din   = '0;
    bus2.mute  = '0;
    repeat (3) step();
    checking = 1'b1;
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_dout",  int'(bus.dout), 0);
    check("reset_valid", int'(bus.dout_valid), 0);
    rst_n = 1'b1;
    cen   = 1'b1;
    repeat (2) step();

`ifndef JT49_EXP_RAMP_EN
    run_frame({3{5'h1F}}, 3'b000, lat, val);
    check("full_scale_dout", val, 3069);
    check("full_scale_latency", lat, 4);
    repeat (2) step();
    run_frame({3{5'h0F}}, 3'b000, lat, val);
    check("mid_level_dout", val, 192);
    repeat (2) step();
    run_frame({3{5'h0F}}, 3'b010, lat, val);
    check("muted_ch1_dout", val, 128);
    repeat (6) step();
    check("dout_hold", int'(bus.dout), 128);
`endif

    // abort a frame while it is converting
    bus.din   = {3{5'h1F}};
    bus.mute  = '0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("conv_busy_before_reset", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  int'(bus.busy), 0);
    check("abort_dout",  int'(bus.dout), 0);
    check("abort_valid", int'(bus.dout_valid), 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.dout_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    #1;
    rst_n = 1'b1;
    step();
    run_frame({3{5'h1F}}, 3'b000, lat, val);
    check("after_abort_latency", lat, 4);
`ifndef JT49_EXP_RAMP_EN
    check("after_abort_dout", val, 3069);
`endif
    repeat (2) step();

    // start held high: one frame every CH+2 cycles
    bus.start = 1'b1;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.dout_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    #1;
    bus.start = 1'b0;
    check("held_start_pulses", pulses, 5);
    check("held_start_first", first, 4);
    repeat (3) step();

    // randomized traffic with cen gaps, retriggers and occasional reset
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      cen       = ($urandom_range(0, 3) != 0);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.din   = CH*5'($urandom);
      bus.mute  = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
    end
    step();
    rst_n     = 1'b1;
    cen       = 1'b1;
    bus.start = 1'b0;
    repeat (8) step();

    // single-channel 8-bit instance: sum is the raw table entry
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int l = 0; l < 32; l++) begin
      bus2.din   = 5'(l);
      bus2.mute  = 1'b0;
      bus2.start = 1'b1;
      step();
      bus2.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (bus2.dout_valid) begin
          lat = i;
          break;
        end
      end
      check("sweep_latency", lat, 2);
      check($sformatf("sweep_L%0d", l), int'(bus2.dout), tbl[l]);
      #1;
    end
    check("sweep_top", int'(bus2.dout), 255);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt49_exp_mux.md
JT49_EXP_MUX -- requirements
Module: jt49_exp_mux

Interface
REQ-001 SHALL provide parameter CH, default 3, meaning the number of channels (1..8).
REQ-002 SHALL provide parameter DW, default 10, meaning the per-channel linear width (8..16).
REQ-003 SHALL provide parameter SW, default DW+$clog2(CH+1), meaning the sum output width.
REQ-004 SHALL provide port clk  input  1  system clock.
REQ-005 SHALL provide port rst_n  input  1  reset, asynchronous and active-low; single clock domain.
REQ-006 SHALL provide port cen  input  1  clock enable; all state advances only when cen=1.
REQ-007 SHALL provide port start  input  1  request one conversion frame.
REQ-008 SHALL provide port din  input  CH*5  packed 5-bit log levels; channel k is din[5k+4:5k].
REQ-009 SHALL provide port mute  input  CH  per-channel mute; 1 forces that channel's linear value to 0.
REQ-010 SHALL provide port busy  output  1  high while a frame is in progress.
REQ-011 SHALL provide port dout  output  SW  registered sum of the channel linear values.
REQ-012 SHALL provide port dout_valid  output  1  one-clk pulse when dout updates.

Function
REQ-013 SHALL map level L to an 8-bit value T(L) = 0,1,2,2,2,3,3,4,5,6,7,8,9,11,13,16,19,23,27,32,38,45,54,64,76,90,107,128,152,180,214,255 for L = 0..31.
REQ-014 SHALL widen T to DW bits as lin = (T << (DW-8)) | (T >> (16-DW)), so that L=31 gives all ones.
REQ-015 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE.
REQ-016 IDLE: on a cen cycle with start=1, SHALL capture din and mute, clear the accumulator and channel index, and enter CONV.
REQ-017 CONV: on each cen cycle SHALL add the lin value of channel idx (0 if muted) to the accumulator and increment idx; after channel CH-1 SHALL enter DONE.
REQ-018 DONE: on the next cen cycle SHALL load dout from the accumulator, pulse dout_valid for exactly one clk, and return to IDLE.
REQ-019 Latency from the accepted start to dout_valid SHALL be CH+1 cen cycles; with cen tied high, CH+1 clks.
REQ-020 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored and not queued; start in DONE SHALL be accepted only on the following IDLE cen cycle.
REQ-022 Changes on din or mute during a frame SHALL NOT affect that frame.
REQ-023 The accumulator SHALL be SW bits and SHALL never overflow; no saturation logic is needed.
REQ-024 cen=0 SHALL freeze the FSM, index, and accumulator; dout_valid SHALL remain 0.
REQ-025 dout SHALL hold its value between frames.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, idx=0, accumulator=0, dout=0, dout_valid=0, busy=0, and all ramp registers=0.
REQ-027 Reset in mid-frame SHALL abort the frame without a dout_valid pulse.

Configuration
REQ-028 Macro JT49_EXP_RAMP_EN, when defined, SHALL add a per-channel 5-bit applied-level register.
REQ-029 With JT49_EXP_RAMP_EN, each frame SHALL step each channel's applied level by at most 1 toward the captured target, and SHALL use the stepped value for the lookup.
REQ-030 With JT49_EXP_RAMP_EN, mute SHALL ramp the target to 0 rather than forcing 0.
REQ-031 Without JT49_EXP_RAMP_EN, the captured level SHALL be used directly; there SHALL be no ramp registers and no timing difference.

Structure
REQ-032 The 32-entry table and the widening function SHALL live in shared package jt49_exp_pkg, together with the FSM state typedef.
REQ-033 Lookup plus widening SHALL be sub-module jt49_exp_lin (combinational, parameter DW); the top SHALL instantiate one copy and time-multiplex it.

Verification
REQ-034 CH=3, DW=10, din all 5'h1F, mute=0, start -> dout=3069 with dout_valid after 4 cen cycles.
REQ-035 din all 5'h0F -> dout=192; set mute=3'b010 -> dout=128.
REQ-036 DW=8, CH=1, sweep L=0..31 -> dout equals T(L) exactly.
REQ-037 Hold start high continuously -> one frame per 5 cen cycles; extra starts while busy are ignored.
REQ-038 Drop rst_n while in CONV -> outputs are 0 immediately, no dout_valid; next start completes normally.
REQ-039 JT49_EXP_RAMP_EN, CH=1, din 0 -> 5'h1F -> successive frames step through levels 1,2,3,... and reach 255-equivalent after 31 frames.
